// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings: 4-bit ALU opcodes, ALUOp class codes,
// R-type funct codes and the sequencer state encoding.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND        = 4'b0000;
    localparam logic [3:0] ALU_OR         = 4'b0001;
    localparam logic [3:0] ALU_NOR        = 4'b0010;
    localparam logic [3:0] ALU_ADD        = 4'b0011;
    localparam logic [3:0] ALU_SUB        = 4'b0100;
    localparam logic [3:0] ALU_XOR        = 4'b0101;
    localparam logic [3:0] ALU_MEM        = 4'b0110;
    localparam logic [3:0] ALU_LUI        = 4'b0111;
    localparam logic [3:0] ALU_SLL        = 4'b1000;
    localparam logic [3:0] ALU_OP_ILLEGAL = 4'b1001;
    localparam logic [3:0] ALU_SRL        = 4'b1010;
    localparam logic [3:0] ALU_MULT       = 4'b1011;
    localparam logic [3:0] ALU_DIV        = 4'b1100;

    localparam logic [2:0] OPC_RTYPE  = 3'b111;
    localparam logic [2:0] OPC_LUI    = 3'b110;
    localparam logic [2:0] OPC_ORI    = 3'b101;
    localparam logic [2:0] OPC_ADDI   = 3'b100;
    localparam logic [2:0] OPC_BRANCH = 3'b011;
    localparam logic [2:0] OPC_MEM    = 3'b010;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } seq_state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational {ALUOp, ALUFunction} -> 4-bit ALU opcode decoder, flagging
// multi-cycle (MULT/DIV) and undecodable codes.
module alu_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] ALUOp,
    input  logic [5:0] ALUFunction,
    output logic [3:0] op,
    output logic       is_multi,
    output logic       is_illegal
);

    always_comb begin
        op         = ALU_OP_ILLEGAL;
        is_multi   = 1'b0;
        is_illegal = 1'b1;
        case (ALUOp)
            OPC_RTYPE: begin
                is_illegal = 1'b0;
                case (ALUFunction)
                    FN_SLL:  op = ALU_SLL;
                    FN_SRL:  op = ALU_SRL;
                    FN_ADD:  op = ALU_ADD;
                    FN_SUB:  op = ALU_SUB;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_XOR:  op = ALU_XOR;
                    FN_NOR:  op = ALU_NOR;
                    FN_MULT: begin op = ALU_MULT; is_multi = 1'b1; end
                    FN_DIV:  begin op = ALU_DIV;  is_multi = 1'b1; end
                    default: is_illegal = 1'b1;
                endcase
            end
            OPC_LUI:    begin op = ALU_LUI; is_illegal = 1'b0; end
            OPC_ORI:    begin op = ALU_OR;  is_illegal = 1'b0; end
            OPC_ADDI:   begin op = ALU_ADD; is_illegal = 1'b0; end
            OPC_BRANCH: begin op = ALU_XOR; is_illegal = 1'b0; end
            OPC_MEM:    begin op = ALU_MEM; is_illegal = 1'b0; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU opcode sequencer: 1-cycle decode latency under valid/ready,
// with a countdown FSM that stalls upstream for the MULT/DIV duration.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] ALUOp,
    input  logic [5:0] ALUFunction,
    output logic [3:0] ALUOperation,
    output logic       out_valid,
    output logic       multi_start,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_WIDTH  = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_WIDTH-1:0] MULT_LOAD = CNT_WIDTH'(MULT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_LOAD  = CNT_WIDTH'(DIV_CYCLES - 1);

    if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cycles
        $fatal(1, "alu_op_sequencer: MULT_CYCLES and DIV_CYCLES must be >= 1");
    end

    seq_state_t           r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]           r_alu_op;
    logic                 r_out_valid, r_multi_start, r_done, r_illegal;

    logic [3:0] w_dec_op;
    logic       w_dec_multi, w_dec_illegal;
    logic       w_accept, w_finish;

    alu_decode u_decode (
        .ALUOp       (ALUOp),
        .ALUFunction (ALUFunction),
        .op          (w_dec_op),
        .is_multi    (w_dec_multi),
        .is_illegal  (w_dec_illegal)
    );

    assign in_ready = (r_state == ST_IDLE) && !flush;
    assign w_accept = in_valid && in_ready;
    // Natural completion only; a flush leaves BUSY without a done pulse.
    assign w_finish = (r_state == ST_BUSY) && !flush && (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_dec_multi) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = (w_dec_op == ALU_DIV) ? DIV_LOAD : MULT_LOAD;
                end
            end
            ST_BUSY: begin
                if (flush || r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_alu_op      <= ALU_OP_ILLEGAL;
            r_out_valid   <= 1'b0;
            r_multi_start <= 1'b0;
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_out_valid   <= w_accept;
            r_multi_start <= w_accept && w_dec_multi;
            r_illegal     <= w_accept && w_dec_illegal;
            r_done        <= w_finish;
            if (w_accept) begin
                r_alu_op <= w_dec_op;
            end
        end
    end

    assign ALUOperation = r_alu_op;
    assign out_valid    = r_out_valid;
    assign multi_start  = r_multi_start;
    assign done         = r_done;
    assign illegal      = r_illegal;
    assign busy         = (r_state == ST_BUSY);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: decode vector table, hand-built multi-cycle
// sequences, then random traffic against a cycle-indexed reference model.
module tb_alu_op_sequencer;

    localparam int N_MULT = 4;
    localparam int N_DIV  = 32;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, in_ready;
    logic [2:0] ALUOp;
    logic [5:0] ALUFunction;
    logic [3:0] ALUOperation;
    logic       out_valid, multi_start, busy, done, illegal;

    int n_chk  = 0;
    int n_fail = 0;

    alu_op_sequencer #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ALUOp        (ALUOp),
        .ALUFunction  (ALUFunction),
        .ALUOperation (ALUOperation),
        .out_valid    (out_valid),
        .multi_start  (multi_start),
        .busy         (busy),
        .done         (done),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] aluop;
        logic [5:0] funct;
        logic [3:0] op;
        logic       ill;
        logic       ms;
    } vec_t;

    typedef struct {
        logic [2:0] aluop;
        bit         wild;
        logic [5:0] funct;
        logic [3:0] code;
    } dec_ent_t;

    vec_t     vecs[16];
    dec_ent_t dtab[15];

    // Reference decode: first matching row of the opcode table, else illegal.
    function automatic logic [3:0] ref_dec(input logic [2:0] a, input logic [5:0] f);
        for (int i = 0; i < 15; i++)
            if (dtab[i].aluop == a && (dtab[i].wild || dtab[i].funct == f))
                return dtab[i].code;
        return 4'b1001;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] a, input logic [5:0] f);
        ALUOp       = a;
        ALUFunction = f;
        in_valid    = 1'b1;
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        #1;
        while (!in_ready && k < 64) begin
            tick();
            k++;
        end
        chk(nm, in_ready, 1);
    endtask

    // Random-phase reference state, expressed in absolute cycle indices.
    int         c, busy_end, done_at;
    logic [3:0] e_op, code;
    logic       e_ov, e_ms, e_ill, e_ready, acc, is_multi, seen_done;

    initial begin
        dtab[0]  = '{3'b111, 1'b0, 6'b000000, 4'b1000};
        dtab[1]  = '{3'b111, 1'b0, 6'b000010, 4'b1010};
        dtab[2]  = '{3'b111, 1'b0, 6'b100000, 4'b0011};
        dtab[3]  = '{3'b111, 1'b0, 6'b100010, 4'b0100};
        dtab[4]  = '{3'b111, 1'b0, 6'b100100, 4'b0000};
        dtab[5]  = '{3'b111, 1'b0, 6'b100101, 4'b0001};
        dtab[6]  = '{3'b111, 1'b0, 6'b100110, 4'b0101};
        dtab[7]  = '{3'b111, 1'b0, 6'b100111, 4'b0010};
        dtab[8]  = '{3'b111, 1'b0, 6'b011000, 4'b1011};
        dtab[9]  = '{3'b111, 1'b0, 6'b011010, 4'b1100};
        dtab[10] = '{3'b110, 1'b1, 6'b000000, 4'b0111};
        dtab[11] = '{3'b101, 1'b1, 6'b000000, 4'b0001};
        dtab[12] = '{3'b100, 1'b1, 6'b000000, 4'b0011};
        dtab[13] = '{3'b011, 1'b1, 6'b000000, 4'b0101};
        dtab[14] = '{3'b010, 1'b1, 6'b000000, 4'b0110};

        vecs[0]  = '{3'b011, 6'b101010, 4'b0101, 1'b0, 1'b0};
        vecs[1]  = '{3'b111, 6'b100110, 4'b0101, 1'b0, 1'b0};
        vecs[2]  = '{3'b110, 6'b000000, 4'b0111, 1'b0, 1'b0};
        vecs[3]  = '{3'b111, 6'b000000, 4'b1000, 1'b0, 1'b0};
        vecs[4]  = '{3'b111, 6'b000010, 4'b1010, 1'b0, 1'b0};
        vecs[5]  = '{3'b111, 6'b100010, 4'b0100, 1'b0, 1'b0};
        vecs[6]  = '{3'b111, 6'b100111, 4'b0010, 1'b0, 1'b0};
        vecs[7]  = '{3'b111, 6'b100101, 4'b0001, 1'b0, 1'b0};
        vecs[8]  = '{3'b100, 6'b111111, 4'b0011, 1'b0, 1'b0};
        vecs[9]  = '{3'b010, 6'b000001, 4'b0110, 1'b0, 1'b0};
        vecs[10] = '{3'b000, 6'b100000, 4'b1001, 1'b1, 1'b0};
        vecs[11] = '{3'b001, 6'b000000, 4'b1001, 1'b1, 1'b0};
        vecs[12] = '{3'b111, 6'b111111, 4'b1001, 1'b1, 1'b0};
        vecs[13] = '{3'b111, 6'b011000, 4'b1011, 1'b0, 1'b1};
        vecs[14] = '{3'b111, 6'b011010, 4'b1100, 1'b0, 1'b1};
        vecs[15] = '{3'b101, 6'b010101, 4'b0001, 1'b0, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        ALUOp = 3'b000; ALUFunction = 6'b000000;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst op", ALUOperation, 4'b1001);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst illegal", illegal, 0);
        chk("rst in_ready", in_ready, 1);

        // Back-to-back single-cycle ops: ADD, AND, ORI
        drive(3'b111, 6'b100000); tick();
        chk("b2b add op", ALUOperation, 4'b0011); chk("b2b add ov", out_valid, 1);
        drive(3'b111, 6'b100100); #1; chk("b2b ready1", in_ready, 1); tick();
        chk("b2b and op", ALUOperation, 4'b0000); chk("b2b and ov", out_valid, 1);
        chk("b2b busy", busy, 0);
        drive(3'b101, 6'b000000); #1; chk("b2b ready2", in_ready, 1); tick();
        in_valid = 1'b0;
        chk("b2b ori op", ALUOperation, 4'b0001); chk("b2b ori ov", out_valid, 1);
        tick();
        chk("b2b idle ov", out_valid, 0);
        chk("b2b hold op", ALUOperation, 4'b0001);

        // Decode table, one op at a time
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].aluop, vecs[i].funct);
            #1; chk($sformatf("vec%0d ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d op", i), ALUOperation, vecs[i].op);
            chk($sformatf("vec%0d ov", i), out_valid, 1);
            chk($sformatf("vec%0d ill", i), illegal, vecs[i].ill);
            chk($sformatf("vec%0d ms", i), multi_start, vecs[i].ms);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].ms);
            tick();
            chk($sformatf("vec%0d ill pulse", i), illegal, 0);
            wait_ready($sformatf("vec%0d wait", i));
            tick();
        end

        // MULT with a SUB held on in_valid throughout BUSY
        drive(3'b111, 6'b011000); tick();
        chk("mult op", ALUOperation, 4'b1011); chk("mult ov", out_valid, 1);
        drive(3'b111, 6'b100010);
        for (int k = 1; k <= N_MULT; k++) begin
            #1;
            chk($sformatf("mult busy c%0d", k), busy, 1);
            chk($sformatf("mult ready c%0d", k), in_ready, 0);
            chk($sformatf("mult ms c%0d", k), multi_start, (k == 1));
            chk($sformatf("mult done c%0d", k), done, 0);
            tick();
        end
        chk("mult done", done, 1);
        chk("mult done busy", busy, 0);
        chk("mult done ready", in_ready, 1);
        chk("mult done ov", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("mult sub op", ALUOperation, 4'b0100);
        chk("mult sub ov", out_valid, 1);
        chk("mult done pulse", done, 0);

        // DIV flushed in its 10th busy cycle, flush beating a pending LW
        tick();
        drive(3'b111, 6'b011010); tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("div busy10", busy, 1);
        flush = 1'b1; drive(3'b010, 6'b000000);
        #1; chk("div flush ready", in_ready, 0);
        tick();
        flush = 1'b0;
        chk("div flushed busy", busy, 0);
        chk("div flushed done", done, 0);
        chk("div flushed ov", out_valid, 0);
        chk("div flushed op", ALUOperation, 4'b1100);
        #1; chk("div flushed ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("div lw op", ALUOperation, 4'b0110);
        chk("div lw ov", out_valid, 1);
        seen_done = 1'b0;
        repeat (40) begin tick(); seen_done |= done; end
        chk("div no done", seen_done, 0);

        // Flush in IDLE only blocks acceptance for that cycle
        flush = 1'b1; drive(3'b110, 6'b000000);
        #1; chk("idle flush ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("idle flush ov", out_valid, 0);
        chk("idle flush op", ALUOperation, 4'b0110);

        // Reset (with flush) in 2nd busy cycle of MULT
        drive(3'b111, 6'b011000); tick();
        in_valid = 1'b0;
        tick();
        chk("rstmid busy", busy, 1);
        reset = 1'b1; flush = 1'b1;
        tick();
        chk("rstmid op", ALUOperation, 4'b1001);
        chk("rstmid ov", out_valid, 0);
        chk("rstmid ms", multi_start, 0);
        chk("rstmid busy0", busy, 0);
        chk("rstmid done", done, 0);
        chk("rstmid ill", illegal, 0);
        reset = 1'b0; flush = 1'b0;
        #1; chk("rstmid ready", in_ready, 1);
        seen_done = 1'b0;
        repeat (8) begin tick(); seen_done |= done; end
        chk("rstmid no done", seen_done, 0);

        // Random traffic against the reference model
        e_op = 4'b1001; e_ov = 1'b0; e_ms = 1'b0; e_ill = 1'b0;
        busy_end = -1; done_at = -1;
        for (c = 0; c < 1500; c++) begin
            chk("rnd op", ALUOperation, e_op);
            chk("rnd ov", out_valid, e_ov);
            chk("rnd ms", multi_start, e_ms);
            chk("rnd ill", illegal, e_ill);
            chk("rnd done", done, (done_at == c));
            chk("rnd busy", busy, (c <= busy_end));

            in_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) < 16) begin
                vec_t v;
                v = vecs[$urandom_range(0, 15)];
                ALUOp = v.aluop; ALUFunction = v.funct;
            end else begin
                ALUOp = 3'($urandom); ALUFunction = 6'($urandom);
            end
            #1;
            e_ready = (c > busy_end) && !flush;
            chk("rnd ready", in_ready, e_ready);

            acc      = in_valid && e_ready;
            code     = ref_dec(ALUOp, ALUFunction);
            is_multi = (code == 4'b1011) || (code == 4'b1100);
            if (acc) e_op = code;
            e_ov  = acc;
            e_ms  = acc && is_multi;
            e_ill = acc && (code == 4'b1001);
            if (acc && is_multi) begin
                busy_end = c + ((code == 4'b1100) ? N_DIV : N_MULT);
                done_at  = busy_end + 1;
            end else if (flush && c <= busy_end) begin
                busy_end = c;
                done_at  = -1;
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
